// File: rtl/sr_cmd_driver.sv
// Command stage for an SR flip-flop: conditions set/clear/toggle buttons,
// arbitrates them and issues single-cycle, mutually exclusive s/r pulses.
module sr_cmd_driver #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter bit          CLR_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  input  logic tgl_btn,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned NBTN  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BSET  = 0;
  localparam int unsigned BCLR  = 1;
  localparam int unsigned BTGL  = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD1 = 2'd2,
    HOLD2 = 2'd3
  } state_t;

  logic [NBTN-1:0]  btn;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  deb;
  logic [NBTN-1:0]  deb_q;
  logic [CNT_W-1:0] cnt [NBTN];
  logic [NBTN-1:0]  req;
  logic [NBTN-1:0]  pend;
  logic [NBTN-1:0]  pend_nxt;
  logic [NBTN-1:0]  eff;

  state_t state;
  state_t state_nxt;
  logic   s_nxt;
  logic   r_nxt;
  logic   conflict_nxt;
  logic   busy_nxt;

  assign btn = {tgl_btn, clr_btn, set_btn};

  // Two-flop synchronizer and per-button debounce; deb flips after
  // DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Request is the rising edge of the debounced level only.
  assign req = deb & ~deb_q;
  assign eff = pend | req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      s        <= s_nxt;
      r        <= r_nxt;
      conflict <= conflict_nxt;
      busy     <= busy_nxt;
    end
  end

  // Arbitration happens only in IDLE; everything pending is consumed there.
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend | req;
    s_nxt        = 1'b0;
    r_nxt        = 1'b0;
    conflict_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|eff) begin
          state_nxt = DRIVE;
          pend_nxt  = '0;
          if (eff[BSET] && eff[BCLR]) begin
            conflict_nxt = 1'b1;
            if (CLR_PRIORITY) r_nxt = 1'b1;
            else              s_nxt = 1'b1;
          end else if (eff[BSET]) begin
            s_nxt = 1'b1;
          end else if (eff[BCLR]) begin
            r_nxt = 1'b1;
          end else if (q_fb) begin
            r_nxt = 1'b1;
          end else begin
            s_nxt = 1'b1;
          end
          // Toggle alongside an explicit command is dropped.
          if (eff[BTGL] && (eff[BSET] || eff[BCLR])) conflict_nxt = 1'b1;
        end
      end
      DRIVE:   state_nxt = HOLD1;
      HOLD1:   state_nxt = HOLD2;
      HOLD2:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver with a behavioural downstream SR flip-flop.
module tb_sr_cmd_driver;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic set_btn = 1'b0;
  logic clr_btn = 1'b0;
  logic tgl_btn = 1'b0;
  logic q_ff;
  logic s, r, busy, conflict;

  int checks   = 0;
  int failures = 0;
  logic [3:0] obs [64];

  always #5 clk = ~clk;

  sr_cmd_driver #(.DEB_CYCLES(4), .CLR_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .tgl_btn(tgl_btn), .q_fb(q_ff), .s(s), .r(r), .busy(busy),
    .conflict(conflict)
  );

  // Downstream SR flip-flop
  always @(posedge clk) begin
    if (rst)          q_ff <= 1'b0;
    else if (s && !r) q_ff <= 1'b1;
    else if (r && !s) q_ff <= 1'b0;
  end

  // Advance n cycles, capturing {s,r,conflict,busy} after each edge.
  task automatic run(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      obs[base + k] = {s, r, conflict, busy};
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      set_btn = ~set_btn; clr_btn = ~clr_btn; tgl_btn = (k == 0);
      run(1, k);
      checks++;
      if (obs[k] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold k=%0d {s,r,conflict,busy}=%b want 0000", k, obs[k]);
      end
    end
    set_btn = 1'b0; clr_btn = 1'b0; tgl_btn = 1'b0;
    rst = 1'b0;
    run(20, 0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs[k] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle k=%0d {s,r,conflict,busy}=%b want 0000", k, obs[k]);
      end
    end
  endtask

  task automatic test_set_clear();
    logic [3:0] exp;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) set_btn = 1'b1; else clr_btn = 1'b1;
      run(10, 0);
      set_btn = 1'b0; clr_btn = 1'b0;
      run(10, 10);
      for (int k = 0; k < 20; k++) begin
        exp = 4'b0000;
        if (k == 6) exp = (p == 0) ? 4'b1001 : 4'b0101;
        else if (k == 7 || k == 8) exp = 4'b0001;
        checks++;
        if (obs[k] !== exp) begin
          failures++;
          $display("FAIL set_clear p=%0d k=%0d {s,r,conflict,busy}=%b want %b", p, k, obs[k], exp);
        end
      end
      checks++;
      if (q_ff !== (p == 0)) begin
        failures++;
        $display("FAIL set_clear_q p=%0d q=%b want %b", p, q_ff, (p == 0));
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp;
    for (int p = 0; p < 3; p++) begin
      tgl_btn = 1'b1;
      run(10, 0);
      tgl_btn = 1'b0;
      run(10, 10);
      for (int k = 0; k < 20; k++) begin
        exp = 4'b0000;
        if (k == 6) exp = (p == 1) ? 4'b0101 : 4'b1001;
        else if (k == 7 || k == 8) exp = 4'b0001;
        checks++;
        if (obs[k] !== exp) begin
          failures++;
          $display("FAIL toggle p=%0d k=%0d {s,r,conflict,busy}=%b want %b", p, k, obs[k], exp);
        end
      end
      checks++;
      if (q_ff !== (p != 1)) begin
        failures++;
        $display("FAIL toggle_q p=%0d q=%b want %b", p, q_ff, (p != 1));
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [3:0] exp;
    pat = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      set_btn = pat[k];
      run(1, k);
    end
    run(15, 5);
    set_btn = 1'b0;
    run(10, 20);
    for (int k = 0; k < 30; k++) begin
      exp = 4'b0000;
      if (k == 10) exp = 4'b1001;
      else if (k == 11 || k == 12) exp = 4'b0001;
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL bounce k=%0d {s,r,conflict,busy}=%b want %b", k, obs[k], exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp;
    for (int p = 0; p < 2; p++) begin
      set_btn = 1'b1; clr_btn = 1'b1; tgl_btn = (p == 1);
      run(10, 0);
      set_btn = 1'b0; clr_btn = 1'b0; tgl_btn = 1'b0;
      run(20, 10);
      for (int k = 0; k < 30; k++) begin
        exp = 4'b0000;
        if (k == 6) exp = 4'b0111;
        else if (k == 7 || k == 8) exp = 4'b0001;
        checks++;
        if (obs[k] !== exp) begin
          failures++;
          $display("FAIL simultaneous p=%0d k=%0d {s,r,conflict,busy}=%b want %b", p, k, obs[k], exp);
        end
      end
    end
    checks++;
    if (q_ff !== 1'b0) begin
      failures++;
      $display("FAIL simultaneous_q q=%b want 0", q_ff);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    set_btn = 1'b1;
    run(2, 0);
    clr_btn = 1'b1;
    run(10, 2);
    set_btn = 1'b0; clr_btn = 1'b0;
    run(12, 12);
    for (int k = 0; k < 24; k++) begin
      exp = 4'b0000;
      if (k == 6) exp = 4'b1001;
      else if (k == 10) exp = 4'b0101;
      else if (k == 7 || k == 8 || k == 11 || k == 12) exp = 4'b0001;
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL back_to_back k=%0d {s,r,conflict,busy}=%b want %b", k, obs[k], exp);
      end
    end
    checks++;
    if (q_ff !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_q q=%b want 0", q_ff);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    set_btn = 1'b1;
    run(1, 0);
    clr_btn = 1'b1;
    run(6, 1);
    rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
    run(2, 7);
    rst = 1'b0;
    run(20, 9);
    for (int k = 6; k < 29; k++) begin
      exp = (k == 6) ? 4'b1001 : 4'b0000;
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL reset_mid k=%0d {s,r,conflict,busy}=%b want %b", k, obs[k], exp);
      end
    end
  endtask

  task automatic test_held_through_reset();
    logic [3:0] exp;
    set_btn = 1'b1;
    run(12, 0);
    rst = 1'b1;
    run(2, 12);
    rst = 1'b0;
    run(16, 14);
    set_btn = 1'b0;
    run(10, 30);
    for (int k = 0; k < 40; k++) begin
      exp = 4'b0000;
      if (k == 6 || k == 20) exp = 4'b1001;
      else if (k == 7 || k == 8 || k == 21 || k == 22) exp = 4'b0001;
      checks++;
      if (obs[k] !== exp) begin
        failures++;
        $display("FAIL held_reset k=%0d {s,r,conflict,busy}=%b want %b", k, obs[k], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_toggle();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_held_through_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
